hazard_ctrl: RTL
================

# hazard_ctrl

Parametrised pipeline hazard and control-flow unit for the three-stage (fetch / decode / execute+writeback) RAT pipeline. It generates EX and WB operand-forwarding selects and load-use stalls. It also runs a small FSM that squashes a configurable number of wrong-path slots after a taken branch or interrupt entry, and keeps a saturating bubble-cycle counter. It sits beside the decoder and drives the PC, fetch register, decode-to-EX control vector register and operand muxes.

## Interface
Parameters:
- `REG_AW`, default 5: register address width.
- `FLUSH_SLOTS`, default 2: bubble cycles per redirect, range 1..7.
- `FWD_EN`, default 1: 1 = forwarding enabled; 0 = every RAW hazard stalls.
- `CNT_W`, default 16: bubble counter width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `dec_reg_a`, `dec_reg_b` in REG_AW: decode-stage source register addresses.
- `dec_a_read`, `dec_b_read` in 1: the decode-stage instruction actually reads that source.
- `ex_reg` in REG_AW, `ex_wr` in 1: EX destination register and write enable.
- `ex_late` in 1: EX result is not available until WB (scratch-RAM or IN-port source).
- `wb_reg` in REG_AW, `wb_wr` in 1: WB destination register and write enable.
- `ex_branch` in 1, `branch_taken` in 1: EX holds a branch/call/ret; `branch_taken` is its resolved outcome.
- `int_req` in 1: level interrupt request, already gated by the I flag.
- `fetch_stall` out 1: hold the fetch register and the PC-delay register.
- `pc_inc` out 1, `pc_load` out 1, `pc_reset` out 1: PC controls.
- `pc_vec_sel` out 1: force the PC mux to the interrupt vector.
- `dec_nop` out 1: load a bubble into the control vector register.
- `fwd_a`, `fwd_b` out 2: operand select. 00 = register file, 01 = EX result, 10 = WB data.
- `int_ack` out 1: one-cycle interrupt acceptance.
- `bubble_cnt` out CNT_W: saturating count of bubble cycles.

## Operation
- FSM states: RUN, FLUSH. A 3-bit counter `slots` is used only in FLUSH.
- Hazard match: `hitEX_a = dec_a_read & ex_wr & (ex_reg == dec_reg_a)`. `hitWB_a` is defined the same way using `wb_*`. The b-side terms are symmetric.
- Forwarding, when FWD_EN=1:
  - `fwd_a = 01` if `hitEX_a & !ex_late`.
  - Otherwise `fwd_a = 10` if `hitWB_a`.
  - Otherwise `fwd_a = 00`.
  - EX has priority over WB. The b-side is symmetric.
- Forwarding, when FWD_EN=0: `fwd_*` is always 00.
- Stall condition, when FWD_EN=1: `(hitEX_a & ex_late) | (hitEX_b & ex_late)`.
- Stall condition, when FWD_EN=0: any of `hitEX_*` or `hitWB_*`.
- RUN, priority highest first:
  1. **Redirect** (`ex_branch & branch_taken`): `pc_load=1`, `dec_nop=1`, `fetch_stall=0`, `pc_inc=0`.
  2. **Interrupt** (`int_req`): `pc_load=1`, `pc_vec_sel=1`, `int_ack=1`, `dec_nop=1`.
  3. **Stall**: `fetch_stall=1`, `pc_inc=0`, `dec_nop=1`. State stays RUN.
  4. **Else**: `pc_inc=1`, all other control outputs 0.
  - After a redirect or interrupt: if FLUSH_SLOTS>1, go to FLUSH with `slots=FLUSH_SLOTS-1`; otherwise stay in RUN.
- FLUSH:
  - Outputs: `dec_nop=1`, `pc_inc=1`; `int_ack`, `pc_load` and `fetch_stall` are 0.
  - `int_req` and `ex_branch` are ignored, because EX holds only bubbles.
  - Each cycle `slots` decrements. When `slots==1`, the next state is RUN.
- Bubble counter: `bubble_cnt` increments on every cycle with `dec_nop=1 & !rst`. It saturates at all-ones and never wraps.
- Reset (`rst=1`), which overrides everything:
  - Outputs in the reset cycle: `pc_reset=1`, `dec_nop=1`, `fetch_stall=0`, `pc_inc=0`, `pc_load=0`, `pc_vec_sel=0`, `int_ack=0`, `fwd_*=00`.
  - On the clock edge: state becomes RUN, `slots=0`, `bubble_cnt=0`.
  - A reset asserted during FLUSH aborts the flush immediately.

## Timing
- All outputs except `bubble_cnt` are combinational from the inputs, the state and `slots`. Zero-cycle latency.
- State, `slots` and `bubble_cnt` update on the rising edge of `clk`.
- Stall cost:
  - A load-use stall costs exactly 1 bubble.
  - The next cycle the producer is in WB, so the consumer gets `fwd=10` and proceeds.
- Redirect or interrupt cost: exactly FLUSH_SLOTS consecutive `dec_nop` cycles. This is the redirect cycle plus FLUSH_SLOTS-1 FLUSH cycles.
- If `int_req` is held high during FLUSH, it is taken on the first RUN cycle.
- If `int_req` and a taken branch arrive together, the branch wins. The interrupt is taken after the flush.
- A register read with both `hitEX` and `hitWB` set forwards from EX.

## Test plan
- **Reset.** Hold `rst` 2 cycles, then release with all inputs 0 → during reset `pc_reset=1`, `dec_nop=1`, `bubble_cnt=0`. First post-reset cycle: `pc_inc=1`, `fwd_a=fwd_b=00`.
- **Forwarding priority.**
  - `dec_reg_a=3`, `dec_a_read=1`, `ex_reg=3`, `ex_wr=1`, `wb_reg=3`, `wb_wr=1` → `fwd_a=01`, no stall.
  - Drop `ex_wr` → `fwd_a=10`.
  - Set `dec_a_read=0` → `fwd_a=00`.
- **Load-use.** `dec_reg_b=5`, `dec_b_read=1`, `ex_reg=5`, `ex_wr=1`, `ex_late=1` → exactly 1 cycle of `fetch_stall=1`, `dec_nop=1`, `pc_inc=0`. The next cycle, with the producer moved to WB: `fwd_b=10`, `bubble_cnt=1`.
- **Taken branch, FLUSH_SLOTS=2.** `ex_branch=1`, `branch_taken=1` → `pc_load=1` and `dec_nop=1` in that cycle, `dec_nop=1` for one more cycle, then RUN with `pc_inc=1`; `bubble_cnt` increases by 2. With `branch_taken=0` → no bubble.
- **Interrupt versus branch.**
  - `int_req=1` together with a taken branch → cycle 0 is `pc_load=1`, `int_ack=0`.
  - With `int_req` held, FLUSH ignores it.
  - The first RUN cycle gives `int_ack=1`, `pc_vec_sel=1`.
  - Asserting `rst` in the first FLUSH cycle returns the FSM to RUN with no `int_ack`.
- **Variants.**
  - FWD_EN=0 with a WB-only match → 1-cycle stall, `fwd=00`.
  - CNT_W=2, with 5 forced bubbles → `bubble_cnt=3`, saturated.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/EX/WB hazard inputs and PC/pipeline controls.
// The slave side is the hazard unit; the master side drives the pipeline state.
interface hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic [REG_AW-1:0] dec_reg_a;
   logic [REG_AW-1:0] dec_reg_b;
   logic              dec_a_read;
   logic              dec_b_read;
   logic [REG_AW-1:0] ex_reg;
   logic              ex_wr;
   logic              ex_late;
   logic [REG_AW-1:0] wb_reg;
   logic              wb_wr;
   logic              ex_branch;
   logic              branch_taken;
   logic              int_req;
   logic              fetch_stall;
   logic              pc_inc;
   logic              pc_load;
   logic              pc_reset;
   logic              pc_vec_sel;
   logic              dec_nop;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;
   logic              int_ack;
   logic [CNT_W-1:0]  bubble_cnt;

   modport master (
      output dec_reg_a, dec_reg_b, dec_a_read, dec_b_read,
      output ex_reg, ex_wr, ex_late, wb_reg, wb_wr,
      output ex_branch, branch_taken, int_req,
      input  fetch_stall, pc_inc, pc_load, pc_reset, pc_vec_sel,
      input  dec_nop, fwd_a, fwd_b, int_ack, bubble_cnt
   );

   modport slave (
      input  dec_reg_a, dec_reg_b, dec_a_read, dec_b_read,
      input  ex_reg, ex_wr, ex_late, wb_reg, wb_wr,
      input  ex_branch, branch_taken, int_req,
      output fetch_stall, pc_inc, pc_load, pc_reset, pc_vec_sel,
      output dec_nop, fwd_a, fwd_b, int_ack, bubble_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use stalls, redirect/interrupt
// squash FSM and a saturating bubble counter for the 3-stage pipeline.
module hazard_ctrl #(
   parameter int REG_AW      = 5,
   parameter int FLUSH_SLOTS = 2,
   parameter int FWD_EN      = 1,
   parameter int CNT_W       = 16
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz
);
   typedef enum logic {RUN, FLUSH} state_e;

   localparam logic [2:0] SLOTS_INIT = 3'(FLUSH_SLOTS - 1);

   state_e            st_q, st_d;
   logic [2:0]        slots_q, slots_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [REG_AW-1:0] ra, rb, rex, rwb;
   logic              hit_ex_a, hit_ex_b, hit_wb_a, hit_wb_b;
   logic              stall, redirect, take;
   logic [1:0]        fa, fb;
   logic              fetch_stall, pc_inc, pc_load;
   logic              pc_vec_sel, dec_nop, int_ack;

   assign ra  = hz.dec_reg_a;
   assign rb  = hz.dec_reg_b;
   assign rex = hz.ex_reg;
   assign rwb = hz.wb_reg;

   assign hit_ex_a = hz.dec_a_read & hz.ex_wr & (rex == ra);
   assign hit_ex_b = hz.dec_b_read & hz.ex_wr & (rex == rb);
   assign hit_wb_a = hz.dec_a_read & hz.wb_wr & (rwb == ra);
   assign hit_wb_b = hz.dec_b_read & hz.wb_wr & (rwb == rb);

   assign redirect = hz.ex_branch & hz.branch_taken;

   // Operand selects and RAW stall; EX beats WB, late EX results stall.
   always_comb begin
      fa    = 2'b00;
      fb    = 2'b00;
      stall = 1'b0;
      if (FWD_EN != 0) begin
         if (hit_ex_a & ~hz.ex_late) fa = 2'b01;
         else if (hit_wb_a)          fa = 2'b10;
         if (hit_ex_b & ~hz.ex_late) fb = 2'b01;
         else if (hit_wb_b)          fb = 2'b10;
         stall = hz.ex_late & (hit_ex_a | hit_ex_b);
      end else begin
         stall = hit_ex_a | hit_ex_b | hit_wb_a | hit_wb_b;
      end
      if (rst) begin
         fa = 2'b00;
         fb = 2'b00;
      end
   end

   // Control outputs and next state; reset, then flush, then RUN priorities.
   always_comb begin
      fetch_stall = 1'b0;
      pc_inc      = 1'b0;
      pc_load     = 1'b0;
      pc_vec_sel  = 1'b0;
      dec_nop     = 1'b0;
      int_ack     = 1'b0;
      take        = 1'b0;
      st_d        = st_q;
      slots_d     = slots_q;
      if (rst) begin
         dec_nop = 1'b1;
      end else if (st_q == FLUSH) begin
         dec_nop = 1'b1;
         pc_inc  = 1'b1;
         slots_d = slots_q - 3'd1;
         if (slots_q <= 3'd1) st_d = RUN;
      end else if (redirect) begin
         pc_load = 1'b1;
         dec_nop = 1'b1;
         take    = 1'b1;
      end else if (hz.int_req) begin
         pc_load    = 1'b1;
         pc_vec_sel = 1'b1;
         int_ack    = 1'b1;
         dec_nop    = 1'b1;
         take       = 1'b1;
      end else if (stall) begin
         fetch_stall = 1'b1;
         dec_nop     = 1'b1;
      end else begin
         pc_inc = 1'b1;
      end
      if (take && FLUSH_SLOTS > 1) begin
         st_d    = FLUSH;
         slots_d = SLOTS_INIT;
      end
   end

   // Bubble counter holds at all-ones instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (dec_nop && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
   end

   // State, flush slot count and bubble counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q    <= RUN;
         slots_q <= 3'd0;
         cnt_q   <= '0;
      end else begin
         st_q    <= st_d;
         slots_q <= slots_d;
         cnt_q   <= cnt_d;
      end
   end

   assign hz.fetch_stall = fetch_stall;
   assign hz.pc_inc      = pc_inc;
   assign hz.pc_load     = pc_load;
   assign hz.pc_reset    = rst;
   assign hz.pc_vec_sel  = pc_vec_sel;
   assign hz.dec_nop     = dec_nop;
   assign hz.fwd_a       = fa;
   assign hz.fwd_b       = fb;
   assign hz.int_ack     = int_ack;
   assign hz.bubble_cnt  = cnt_q;
endmodule
